noc_ext_gateway: RTL and testbench
==================================

Name: noc_ext_gateway

Overview:
Multi-channel bridge between the host/memory link and the mesh NoC boundary. It generalises the single ext_* link to NUM_CH boundary channels.
- Ingress: host flits are steered by destination row into per-channel FIFOs that feed the west-edge routers.
- Egress: flits from NUM_CH boundary routers are buffered and merged round-robin onto one registered host output.
- Sits between the SoC host port and the router mesh inside the NPU top level.

Parameters:
NUM_CH, 4, number of boundary channels (1..TILE_ROWS).
FLIT_W, 64, flit width in bits (>=16).
FIFO_DEPTH, 4, entries per channel FIFO, per direction (power of 2, >=2).
TILE_ROWS, 4, mesh rows, used for destination validity (<=16).
TILE_COLS, 4, mesh columns, used for destination validity (<=16).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
ext_flit_in  in  FLIT_W  host-to-NPU flit.
ext_valid_in  in  1  host flit valid.
ext_ready_out  out  1  gateway accepts host flit.
ext_flit_out  out  FLIT_W  NPU-to-host flit, registered.
ext_valid_out  out  1  host output valid, registered.
ext_ready_in  in  1  host accepts output flit.
mesh_flit_out  out  NUM_CH*FLIT_W  flits to boundary routers; channel k at [k*FLIT_W +: FLIT_W].
mesh_valid_out  out  NUM_CH  per-channel valid.
mesh_ready_in  in  NUM_CH  per-channel router ready.
mesh_flit_in  in  NUM_CH*FLIT_W  flits from boundary routers.
mesh_valid_in  in  NUM_CH  per-channel valid.
mesh_ready_out  out  NUM_CH  per-channel gateway ready.
drop_pulse  out  1  one-cycle pulse when an ingress flit is dropped.
stat_in_cnt, stat_out_cnt, stat_drop_cnt  out  16 each  saturating counters.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: all FIFOs empty, all valids 0, ext_flit_out 0, RR pointer 0, counters 0, drop_pulse 0.
- Handshake: a transfer occurs when valid && ready on a rising edge. A valid, once raised, holds until accepted, with data stable.
- Header fields: dst_row = flit[FLIT_W-1 -: 4], dst_col = flit[FLIT_W-5 -: 4].
- Ingress channel select: ch = dst_row % NUM_CH.
- Invalid destination: dst_row >= TILE_ROWS or dst_col >= TILE_COLS.
  - ext_ready_out = 1.
  - The flit is consumed but not written to any FIFO.
  - drop_pulse is asserted the following cycle and stat_drop_cnt increments.
- Valid destination: ext_ready_out = !full[ch]. This is a combinational function of the header and FIFO state; there is no path from ext_valid_in to ext_ready_out.
- Ingress FIFOs are first-word fall-through with no empty bypass.
  - A flit written at edge N is visible on mesh_*_out after edge N, i.e. 1-cycle latency.
  - mesh_valid_out[k] = !empty[k].
  - Pop occurs on valid && mesh_ready_in[k].
  - Full FIFO with a simultaneous pop: ready stays 0 that cycle (no full-pass-through).
- Egress FIFOs: mesh_ready_out[k] = !full[k]. Push occurs on mesh_valid_in[k] && mesh_ready_out[k].
- Egress arbiter:
  - Load condition: output register is empty, or ext_ready_in is high while ext_valid_out is high.
  - On load, the arbiter grants the first non-empty egress FIFO, searching from RR pointer p upward with wrap-around.
  - The granted head is popped into the output register, and p becomes grant+1 (mod NUM_CH).
  - If no FIFO is non-empty on a load cycle, ext_valid_out falls to 0.
  - Latency mesh_in -> ext_out is 2 cycles minimum.
- Back-pressure: while ext_valid_out && !ext_ready_in, ext_flit_out and the pointer are frozen.
- Counters:
  - stat_in_cnt counts accepted valid-destination ingress flits.
  - stat_out_cnt counts completed ext_out transfers.
  - All counters saturate at 16'hFFFF.
- Reset mid-operation: all buffered flits are discarded and all valids are low the cycle after the rst_n-low edge.
- NUM_CH=1: the arbiter degenerates to pass-through and the pointer stays 0.

Optional Feature:
NOC_GW_STATS_EN
- Defined: the three stat counters and drop_pulse are implemented as above.
- Undefined: the counter logic is removed and all stat outputs and drop_pulse are tied to 0. Datapath behaviour is identical.

Decomposition:
- Package noc_gw_pkg holds:
  - localparams HDR_ROW_MSB_OFS=0 and HDR_COL_MSB_OFS=4, and the header field width of 4.
  - A function hdr_dst_valid(row, col, rows, cols).
  - STAT_W=16.
- Sub-module gw_fifo: parametrised FWFT synchronous FIFO with FLIT_W and FIFO_DEPTH parameters, push/pop/full/empty ports, and clk/rst_n. It is instantiated 2*NUM_CH times.

Test Plan:
- Ingress steer: NUM_CH=4, flit dst_row=2/dst_col=1 with valid for 1 cycle -> mesh_valid_out=4'b0100 the next cycle, with the payload matching the input.
- Drop: dst_row=5 with TILE_ROWS=4 -> ready=1, no mesh_valid_out, drop_pulse high 1 cycle, stat_drop_cnt=1.
- Full back-pressure: mesh_ready_in[0]=0 with 5 flits to row 0 at FIFO_DEPTH=4 -> 4 accepted, ext_ready_out=0 on the 5th. Releasing ready -> the 5th is accepted after the first pop.
- Round-robin: all 4 egress channels hold 2 flits each, ext_ready_in=1 -> output order ch0,1,2,3,0,1,2,3, with ext_valid_out continuous after the 2-cycle fill.
- Output stall: ext_ready_in=0 for 3 cycles mid-stream -> ext_flit_out stable, no flit lost or duplicated, stat_out_cnt=8 at the end.
- Reset mid-stream: rst_n=0 for 1 cycle with FIFOs partially full -> all valids 0, counters 0, and subsequent traffic is routed correctly starting from p=0.

Source files
------------

// File: rtl/noc_gw_pkg.sv
// Shared definitions for the NoC external gateway: header field layout,
// statistics width and the destination validity check.
package noc_gw_pkg;

    localparam int HDR_W           = 4;
    localparam int HDR_ROW_MSB_OFS = 0;
    localparam int HDR_COL_MSB_OFS = 4;
    localparam int STAT_W          = 16;

    // A destination is routable only if it addresses an existing tile.
    function automatic logic hdr_dst_valid(input logic [HDR_W-1:0] row,
                                           input logic [HDR_W-1:0] col,
                                           input int rows,
                                           input int cols);
        return (int'(row) < rows) && (int'(col) < cols);
    endfunction

endpackage

// File: rtl/gw_fifo.sv
// First-word-fall-through synchronous FIFO used for every gateway channel.
// Head data is visible on dout whenever empty is low; push is ignored when
// full and pop is ignored when empty, so callers may gate loosely.
module gw_fifo #(
    parameter int FLIT_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [FLIT_W-1:0] din,
    input  logic              pop,
    output logic [FLIT_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/noc_ext_gateway.sv
// Multi-channel bridge between the host link and the mesh west edge.
// Ingress flits are steered by destination row into per-channel FIFOs;
// egress FIFOs are merged round-robin into one registered host output.
// Optional feature macro: NOC_GW_STATS_EN (statistics counters and drop_pulse).
module noc_ext_gateway
    import noc_gw_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FLIT_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int TILE_ROWS  = 4,
    parameter int TILE_COLS  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FLIT_W-1:0]        ext_flit_in,
    input  logic                     ext_valid_in,
    output logic                     ext_ready_out,
    output logic [FLIT_W-1:0]        ext_flit_out,
    output logic                     ext_valid_out,
    input  logic                     ext_ready_in,
    output logic [NUM_CH*FLIT_W-1:0] mesh_flit_out,
    output logic [NUM_CH-1:0]        mesh_valid_out,
    input  logic [NUM_CH-1:0]        mesh_ready_in,
    input  logic [NUM_CH*FLIT_W-1:0] mesh_flit_in,
    input  logic [NUM_CH-1:0]        mesh_valid_in,
    output logic [NUM_CH-1:0]        mesh_ready_out,
    output logic                     drop_pulse,
    output logic [STAT_W-1:0]        stat_in_cnt,
    output logic [STAT_W-1:0]        stat_out_cnt,
    output logic [STAT_W-1:0]        stat_drop_cnt
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [HDR_W-1:0]  dst_row;
    logic [HDR_W-1:0]  dst_col;
    logic              dst_ok;
    logic              sel_full;
    logic [NUM_CH-1:0] in_push, in_pop, in_full, in_empty;
    logic [NUM_CH-1:0] eg_push, eg_pop, eg_full, eg_empty;
    logic [FLIT_W-1:0] eg_head [NUM_CH];
    logic              load;
    logic              gnt_any;
    int                scan_idx;
    int                gnt_idx;
    logic [FLIT_W-1:0] gnt_flit;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_next;

    assign dst_row = ext_flit_in[FLIT_W-1-HDR_ROW_MSB_OFS -: HDR_W];
    assign dst_col = ext_flit_in[FLIT_W-1-HDR_COL_MSB_OFS -: HDR_W];
    assign dst_ok  = hdr_dst_valid(dst_row, dst_col, TILE_ROWS, TILE_COLS);

    // Steer by row; ready depends only on header and FIFO state, never on valid.
    always_comb begin
        in_push  = '0;
        sel_full = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == int'(dst_row) % NUM_CH) begin
                sel_full   = in_full[k];
                in_push[k] = ext_valid_in && dst_ok && !in_full[k];
            end
        end
        ext_ready_out = dst_ok ? !sel_full : 1'b1;
    end

    assign mesh_valid_out = ~in_empty;
    assign in_pop         = ~in_empty & mesh_ready_in;
    assign mesh_ready_out = ~eg_full;
    assign eg_push        = mesh_valid_in & ~eg_full;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        gw_fifo #(.FLIT_W(FLIT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_in_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_push[g]),
            .din   (ext_flit_in),
            .pop   (in_pop[g]),
            .dout  (mesh_flit_out[g*FLIT_W +: FLIT_W]),
            .full  (in_full[g]),
            .empty (in_empty[g])
        );
        gw_fifo #(.FLIT_W(FLIT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_eg_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (eg_push[g]),
            .din   (mesh_flit_in[g*FLIT_W +: FLIT_W]),
            .pop   (eg_pop[g]),
            .dout  (eg_head[g]),
            .full  (eg_full[g]),
            .empty (eg_empty[g])
        );
    end

    // Round-robin search from rr_ptr upward; pop only when the output loads.
    always_comb begin
        load     = !ext_valid_out || ext_ready_in;
        gnt_any  = 1'b0;
        gnt_idx  = 0;
        scan_idx = 0;
        gnt_flit = '0;
        eg_pop   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_CH;
            for (int k = 0; k < NUM_CH; k++) begin
                if (!gnt_any && k == scan_idx && !eg_empty[k]) begin
                    gnt_any = 1'b1;
                    gnt_idx = k;
                end
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_any && k == gnt_idx) begin
                gnt_flit  = eg_head[k];
                eg_pop[k] = load;
            end
        end
        rr_next = CH_W'((gnt_idx + 1) % NUM_CH);
    end

    // Host output register: frozen under back-pressure, reloaded otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_valid_out <= 1'b0;
            ext_flit_out  <= '0;
            rr_ptr        <= '0;
        end else if (load) begin
            ext_valid_out <= gnt_any;
            if (gnt_any) begin
                ext_flit_out <= gnt_flit;
                rr_ptr       <= rr_next;
            end
        end
    end

`ifdef NOC_GW_STATS_EN
    logic drop_evt;
    logic in_acc;
    logic out_acc;

    assign drop_evt = ext_valid_in && !dst_ok;
    assign in_acc   = |in_push;
    assign out_acc  = ext_valid_out && ext_ready_in;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    // Traffic statistics, each counter saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_pulse    <= 1'b0;
            stat_in_cnt   <= '0;
            stat_out_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            drop_pulse <= drop_evt;
            if (in_acc)   stat_in_cnt   <= sat_inc(stat_in_cnt);
            if (out_acc)  stat_out_cnt  <= sat_inc(stat_out_cnt);
            if (drop_evt) stat_drop_cnt <= sat_inc(stat_drop_cnt);
        end
    end
`else
    assign drop_pulse    = 1'b0;
    assign stat_in_cnt   = '0;
    assign stat_out_cnt  = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_ext_gateway.sv
// Directed bench for noc_ext_gateway at NUM_CH=4, FLIT_W=64, FIFO_DEPTH=4,
// 4x4 mesh. Statistic expectations follow the NOC_GW_STATS_EN build setting.
module tb_noc_ext_gateway;

    localparam int NC = 4;
    localparam int FW = 64;
`ifdef NOC_GW_STATS_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [FW-1:0]    ext_flit_in;
    logic             ext_valid_in;
    logic             ext_ready_out;
    logic [FW-1:0]    ext_flit_out;
    logic             ext_valid_out;
    logic             ext_ready_in;
    logic [NC*FW-1:0] mesh_flit_out;
    logic [NC-1:0]    mesh_valid_out;
    logic [NC-1:0]    mesh_ready_in;
    logic [NC*FW-1:0] mesh_flit_in;
    logic [NC-1:0]    mesh_valid_in;
    logic [NC-1:0]    mesh_ready_out;
    logic             drop_pulse;
    logic [15:0]      stat_in_cnt, stat_out_cnt, stat_drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [FW-1:0] exp_seq [8];

    noc_ext_gateway #(.NUM_CH(NC), .FLIT_W(FW), .FIFO_DEPTH(4),
                      .TILE_ROWS(4), .TILE_COLS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ext_flit_in    (ext_flit_in),
        .ext_valid_in   (ext_valid_in),
        .ext_ready_out  (ext_ready_out),
        .ext_flit_out   (ext_flit_out),
        .ext_valid_out  (ext_valid_out),
        .ext_ready_in   (ext_ready_in),
        .mesh_flit_out  (mesh_flit_out),
        .mesh_valid_out (mesh_valid_out),
        .mesh_ready_in  (mesh_ready_in),
        .mesh_flit_in   (mesh_flit_in),
        .mesh_valid_in  (mesh_valid_in),
        .mesh_ready_out (mesh_ready_out),
        .drop_pulse     (drop_pulse),
        .stat_in_cnt    (stat_in_cnt),
        .stat_out_cnt   (stat_out_cnt),
        .stat_drop_cnt  (stat_drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [3:0] r, input logic [3:0] c,
                                         input logic [55:0] pl);
        return {r, c, pl};
    endfunction

    function automatic logic [15:0] st(input int n);
        return ST ? 16'(n) : 16'd0;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ext_flit_in = '0; ext_valid_in = 1'b0; ext_ready_in = 1'b0;
        mesh_ready_in = '0; mesh_flit_in = '0; mesh_valid_in = '0;
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_mesh_valid", FW'(mesh_valid_out), 0);
        chk("rst_ext_valid", FW'(ext_valid_out), 0);
        chk("rst_ext_flit", ext_flit_out, 0);
        chk("rst_mesh_ready", FW'(mesh_ready_out), FW'(4'hF));
        chk("rst_ext_ready", FW'(ext_ready_out), 1);
        chk("rst_drop", FW'(drop_pulse), 0);
        chk("rst_stats", FW'({stat_in_cnt, stat_out_cnt, stat_drop_cnt}), 0);

        // Ingress steering: row 2 lands on channel 2 one cycle later
        ext_flit_in = mk(4'd2, 4'd1, 56'hABCD); ext_valid_in = 1'b1;
        #1 chk("steer_ready", FW'(ext_ready_out), 1);
        step();
        ext_valid_in = 1'b0;
        chk("steer_valid", FW'(mesh_valid_out), FW'(4'b0100));
        chk("steer_data", mesh_flit_out[2*FW +: FW], mk(4'd2, 4'd1, 56'hABCD));
        chk("steer_in_cnt", FW'(stat_in_cnt), FW'(st(1)));
        mesh_ready_in = 4'b0100;
        step();
        mesh_ready_in = '0;
        chk("steer_pop", FW'(mesh_valid_out), 0);

        // Drops: bad row, then bad column
        ext_flit_in = mk(4'd5, 4'd0, 56'h11); ext_valid_in = 1'b1;
        #1 chk("drop_ready", FW'(ext_ready_out), 1);
        step();
        ext_valid_in = 1'b0;
        chk("drop_pulse", FW'(drop_pulse), FW'(ST));
        chk("drop_no_mesh", FW'(mesh_valid_out), 0);
        chk("drop_cnt1", FW'(stat_drop_cnt), FW'(st(1)));
        ext_flit_in = mk(4'd1, 4'd4, 56'h22); ext_valid_in = 1'b1;
        step();
        ext_valid_in = 1'b0;
        chk("drop_col_no_mesh", FW'(mesh_valid_out), 0);
        chk("drop_cnt2", FW'(stat_drop_cnt), FW'(st(2)));
        step();
        chk("drop_pulse_end", FW'(drop_pulse), 0);

        // Full back-pressure on channel 0
        for (int i = 0; i < 4; i++) begin
            ext_flit_in = mk(4'd0, 4'd0, 56'(i + 1)); ext_valid_in = 1'b1;
            #1 chk($sformatf("fill_ready%0d", i), FW'(ext_ready_out), 1);
            step();
        end
        ext_flit_in = mk(4'd0, 4'd0, 56'd5);
        #1 chk("full_ready0", FW'(ext_ready_out), 0);
        step();
        chk("full_ready1", FW'(ext_ready_out), 0);
        chk("full_head", mesh_flit_out[0 +: FW], mk(4'd0, 4'd0, 56'd1));
        mesh_ready_in = 4'b0001;
        #1 chk("full_pop_ready", FW'(ext_ready_out), 0);
        step();
        chk("after_pop_ready", FW'(ext_ready_out), 1);
        chk("after_pop_head", mesh_flit_out[0 +: FW], mk(4'd0, 4'd0, 56'd2));
        step();
        ext_valid_in = 1'b0;
        chk("drain_h3", mesh_flit_out[0 +: FW], mk(4'd0, 4'd0, 56'd3));
        step();
        chk("drain_h4", mesh_flit_out[0 +: FW], mk(4'd0, 4'd0, 56'd4));
        step();
        chk("drain_h5", mesh_flit_out[0 +: FW], mk(4'd0, 4'd0, 56'd5));
        step();
        chk("drain_empty", FW'(mesh_valid_out), 0);
        mesh_ready_in = '0;
        chk("in_cnt6", FW'(stat_in_cnt), FW'(st(6)));

        // Round-robin egress, two flits per channel, host always ready
        for (int k = 0; k < NC; k++) begin
            exp_seq[k]     = mk(4'd0, 4'd0, 56'(12'h100 + k));
            exp_seq[k + 4] = mk(4'd0, 4'd0, 56'(12'h200 + k));
        end
        ext_ready_in = 1'b1;
        for (int k = 0; k < NC; k++) mesh_flit_in[k*FW +: FW] = exp_seq[k];
        mesh_valid_in = 4'hF;
        #1 chk("eg_ready", FW'(mesh_ready_out), FW'(4'hF));
        step();
        for (int k = 0; k < NC; k++) mesh_flit_in[k*FW +: FW] = exp_seq[k + 4];
        chk("rr_not_yet", FW'(ext_valid_out), 0);
        step();
        mesh_valid_in = '0;
        chk("rr_valid0", FW'(ext_valid_out), 1);
        chk("rr_out0", ext_flit_out, exp_seq[0]);
        for (int j = 1; j < 8; j++) begin
            step();
            chk($sformatf("rr_valid%0d", j), FW'(ext_valid_out), 1);
            chk($sformatf("rr_out%0d", j), ext_flit_out, exp_seq[j]);
        end
        step();
        chk("rr_done", FW'(ext_valid_out), 0);
        chk("out_cnt8", FW'(stat_out_cnt), FW'(st(8)));

        // Output stall for three cycles mid-stream
        for (int k = 0; k < NC; k++) mesh_flit_in[k*FW +: FW] = exp_seq[k];
        mesh_valid_in = 4'hF;
        step();
        for (int k = 0; k < NC; k++) mesh_flit_in[k*FW +: FW] = exp_seq[k + 4];
        step();
        mesh_valid_in = '0;
        chk("st_out0", ext_flit_out, exp_seq[0]);
        step();
        chk("st_out1", ext_flit_out, exp_seq[1]);
        ext_ready_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("st_hold%0d", s), ext_flit_out, exp_seq[1]);
            chk($sformatf("st_hold_v%0d", s), FW'(ext_valid_out), 1);
        end
        ext_ready_in = 1'b1;
        for (int j = 2; j < 8; j++) begin
            step();
            chk($sformatf("st_out%0d", j), ext_flit_out, exp_seq[j]);
        end
        step();
        chk("st_done", FW'(ext_valid_out), 0);
        chk("out_cnt16", FW'(stat_out_cnt), FW'(st(16)));

        // Reset mid-stream with buffered data and a non-zero pointer
        ext_ready_in = 1'b0;
        ext_flit_in = mk(4'd1, 4'd0, 56'h77); ext_valid_in = 1'b1;
        step();
        ext_valid_in = 1'b0;
        mesh_flit_in[2*FW +: FW] = mk(4'd0, 4'd0, 56'h302);
        mesh_valid_in = 4'b0100;
        step();
        mesh_valid_in = '0;
        step();
        chk("pre_rst_out", ext_flit_out, mk(4'd0, 4'd0, 56'h302));
        chk("pre_rst_mesh", FW'(mesh_valid_out), FW'(4'b0010));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_mesh_valid", FW'(mesh_valid_out), 0);
        chk("mid_rst_ext_valid", FW'(ext_valid_out), 0);
        chk("mid_rst_ext_flit", ext_flit_out, 0);
        chk("mid_rst_stats", FW'({stat_in_cnt, stat_out_cnt, stat_drop_cnt}), 0);
        ext_ready_in = 1'b1;
        mesh_flit_in[0*FW +: FW] = mk(4'd0, 4'd0, 56'h400);
        mesh_flit_in[3*FW +: FW] = mk(4'd0, 4'd0, 56'h403);
        mesh_valid_in = 4'b1001;
        step();
        mesh_valid_in = '0;
        step();
        chk("post_rst_first", ext_flit_out, mk(4'd0, 4'd0, 56'h400));
        step();
        chk("post_rst_second", ext_flit_out, mk(4'd0, 4'd0, 56'h403));
        ext_flit_in = mk(4'd3, 4'd3, 56'h55); ext_valid_in = 1'b1;
        step();
        ext_valid_in = 1'b0;
        chk("post_rst_steer", FW'(mesh_valid_out), FW'(4'b1000));
        chk("post_rst_data", mesh_flit_out[3*FW +: FW], mk(4'd3, 4'd3, 56'h55));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
